// File: rtl/axi_ethernet_v3_01_a_ipic_decode_mux.sv
// IPIC address decoder and ack/data return mux
// in front of the Ethernet register blocks.
module axi_ethernet_v3_01_a_ipic_decode_mux #(
  parameter int C_NUM_SLAVES = 4,
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_BASE_ADDRS = 48'h700_600_400_200,
  parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_ADDR_MASKS = 48'h700_700_600_600,
  parameter int C_TIMEOUT = 64
) (
  input  logic bus2ip_clk,
  input  logic bus2ip_resetn,
  input  logic [C_ADDR_WIDTH-1:0] bus2ip_addr,
  input  logic bus2ip_cs,
  input  logic bus2ip_rdce,
  input  logic bus2ip_wrce,
  output logic [C_NUM_SLAVES-1:0] bus2ip_cs_int,
  output logic [C_NUM_SLAVES-1:0] bus2ip_rdce_int,
  output logic [C_NUM_SLAVES-1:0] bus2ip_wrce_int,
  input  logic [C_NUM_SLAVES-1:0] ip2bus_rdack_s,
  input  logic [C_NUM_SLAVES-1:0] ip2bus_wrack_s,
  input  logic [C_NUM_SLAVES-1:0] ip2bus_error_s,
  input  logic [C_NUM_SLAVES*C_DATA_WIDTH-1:0] ip2bus_data_s,
  output logic ip2bus_rdack,
  output logic ip2bus_wrack,
  output logic ip2bus_error,
  output logic [C_DATA_WIDTH-1:0] ip2bus_data,
  output logic timeout_pulse
);

  localparam int NS = C_NUM_SLAVES;
  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int CW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NS-1:0] hit, hit_oh;
  logic [NS-1:0] cs_d, rdi_d, wri_d;
  logic rdack_d, wrack_d, err_d, tp_d;
  logic [DW-1:0] data_d, sel_data;
  logic req, any, sel_rd, sel_wr, sel_err, expire;

  assign any = bus2ip_cs & (bus2ip_rdce | bus2ip_wrce);
  assign req = bus2ip_cs & (bus2ip_rdce ^ bus2ip_wrce);

  // Scan downward so the lowest-index hit is the last one kept
  always_comb begin
    hit = '0;
    hit_oh = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      hit[i] = (bus2ip_addr & C_ADDR_MASKS[i*AW +: AW])
               == C_BASE_ADDRS[i*AW +: AW];
      if (hit[i]) begin
        hit_oh = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NS; i++)
      if (bus2ip_rdce_int[i])
        sel_data = sel_data | ip2bus_data_s[i*DW +: DW];
  end

  assign sel_rd  = |(ip2bus_rdack_s & bus2ip_rdce_int);
  assign sel_wr  = |(ip2bus_wrack_s & bus2ip_wrce_int);
  assign sel_err = |(ip2bus_error_s & bus2ip_cs_int);
  assign expire  = (C_TIMEOUT > 0) && (cnt_q == CW'(1));

  always_ff @(posedge bus2ip_clk or negedge bus2ip_resetn) begin
    if (!bus2ip_resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bus2ip_cs_int <= '0;
      bus2ip_rdce_int <= '0;
      bus2ip_wrce_int <= '0;
      ip2bus_rdack <= 1'b0;
      ip2bus_wrack <= 1'b0;
      ip2bus_error <= 1'b0;
      ip2bus_data <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bus2ip_cs_int <= cs_d;
      bus2ip_rdce_int <= rdi_d;
      bus2ip_wrce_int <= wri_d;
      ip2bus_rdack <= rdack_d;
      ip2bus_wrack <= wrack_d;
      ip2bus_error <= err_d;
      ip2bus_data <= data_d;
      timeout_pulse <= tp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (any)
          state_d = (req && (|hit)) ? BUSY : DONE;
      BUSY:
        if (!bus2ip_cs)
          state_d = IDLE;
        else if (sel_rd || sel_wr || expire)
          state_d = DONE;
      DONE:
        if (!any)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    cs_d = '0;
    rdi_d = '0;
    wri_d = '0;
    rdack_d = 1'b0;
    wrack_d = 1'b0;
    err_d = 1'b0;
    data_d = '0;
    tp_d = 1'b0;
    unique case (state_q)
      IDLE:
        if (req && (|hit)) begin
          cs_d = hit_oh;
          rdi_d = bus2ip_rdce ? hit_oh : '0;
          wri_d = bus2ip_wrce ? hit_oh : '0;
          cnt_d = CW'(C_TIMEOUT);
        end else if (any) begin
          rdack_d = bus2ip_rdce & ~bus2ip_wrce;
          wrack_d = bus2ip_wrce;
          err_d = 1'b1;
        end
      BUSY:
        if (!bus2ip_cs) begin
          cnt_d = '0;
        end else if (sel_rd || sel_wr) begin
          rdack_d = sel_rd;
          wrack_d = sel_wr;
          err_d = sel_err;
          data_d = sel_rd ? sel_data : '0;
        end else if (expire) begin
          rdack_d = |bus2ip_rdce_int;
          wrack_d = |bus2ip_wrce_int;
          err_d = 1'b1;
          tp_d = 1'b1;
        end else begin
          cs_d = bus2ip_cs_int;
          rdi_d = bus2ip_rdce_int;
          wri_d = bus2ip_wrce_int;
          if (C_TIMEOUT > 0)
            cnt_d = cnt_q - CW'(1);
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_ipic_decode_mux.sv
// Randomised transaction bench for the IPIC decode mux
// against a transaction-level reference model.
module tb_axi_ethernet_v3_01_a_ipic_decode_mux;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int T = 8;
  localparam logic [11:0] BASE [4] = '{12'h200, 12'h400, 12'h600, 12'h700};
  localparam logic [11:0] MASK [4] = '{12'h600, 12'h600, 12'h700, 12'h700};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] addr = '0;
  logic cs = 1'b0, rdce = 1'b0, wrce = 1'b0;
  logic [NS-1:0] cs_int, rdce_int, wrce_int;
  logic [NS-1:0] rdack_s = '0, wrack_s = '0, error_s = '0;
  logic [NS*DW-1:0] data_s = '0;
  logic rdack, wrack, error, tp;
  logic [DW-1:0] data;
  logic [5:0] cs2, rd2, wr2;
  logic rdack2, wrack2, err2, tp2;
  logic [DW-1:0] data2;

  always #5 clk = ~clk;

  axi_ethernet_v3_01_a_ipic_decode_mux #(
    .C_NUM_SLAVES(4), .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32),
    .C_BASE_ADDRS(48'h700_600_400_200),
    .C_ADDR_MASKS(48'h700_700_600_600),
    .C_TIMEOUT(T)
  ) dut (
    .bus2ip_clk(clk), .bus2ip_resetn(rst_n),
    .bus2ip_addr(addr), .bus2ip_cs(cs),
    .bus2ip_rdce(rdce), .bus2ip_wrce(wrce),
    .bus2ip_cs_int(cs_int), .bus2ip_rdce_int(rdce_int),
    .bus2ip_wrce_int(wrce_int),
    .ip2bus_rdack_s(rdack_s), .ip2bus_wrack_s(wrack_s),
    .ip2bus_error_s(error_s), .ip2bus_data_s(data_s),
    .ip2bus_rdack(rdack), .ip2bus_wrack(wrack),
    .ip2bus_error(error), .ip2bus_data(data),
    .timeout_pulse(tp)
  );

  axi_ethernet_v3_01_a_ipic_decode_mux #(
    .C_NUM_SLAVES(6), .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32),
    .C_BASE_ADDRS(72'h600_900_800_600_400_200),
    .C_ADDR_MASKS(72'h600_F00_F00_700_600_600),
    .C_TIMEOUT(0)
  ) dut2 (
    .bus2ip_clk(clk), .bus2ip_resetn(rst_n),
    .bus2ip_addr(addr), .bus2ip_cs(cs),
    .bus2ip_rdce(rdce), .bus2ip_wrce(wrce),
    .bus2ip_cs_int(cs2), .bus2ip_rdce_int(rd2),
    .bus2ip_wrce_int(wr2),
    .ip2bus_rdack_s(6'b0), .ip2bus_wrack_s(6'b0),
    .ip2bus_error_s(6'b0), .ip2bus_data_s(192'b0),
    .ip2bus_rdack(rdack2), .ip2bus_wrack(wrack2),
    .ip2bus_error(err2), .ip2bus_data(data2),
    .timeout_pulse(tp2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state: what the outputs must show this cycle
  logic [3:0] e_cs = '0, e_rd = '0, e_wr = '0;
  logic e_rda = 0, e_wra = 0, e_err = 0, e_tp = 0;
  logic [31:0] e_data = '0;

  task automatic set_exp(logic [3:0] c, logic [3:0] r, logic [3:0] w,
                         logic ra, logic wa, logic er,
                         logic [31:0] d, logic t);
    e_cs = c; e_rd = r; e_wr = w;
    e_rda = ra; e_wra = wa; e_err = er; e_data = d; e_tp = t;
  endtask

  task automatic clr_exp();
    set_exp(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 32'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    chk("ints", {cs_int, rdce_int, wrce_int}, {e_cs, e_rd, e_wr});
    chk("acks", {rdack, wrack, error, tp}, {e_rda, e_wra, e_err, e_tp});
    chk("data", data, e_data);
  end

  // Observer for hand-computed expectations of directed tests
  int ack_cnt = 0, run = 0, last_lat = 0;
  logic [31:0] last_data = '0;
  logic last_err = 0, last_tp = 0, last_wr = 0;
  logic [3:0] first_rd = '0;

  always @(negedge clk) begin
    if (rdack === 1'b1 || wrack === 1'b1) begin
      ack_cnt++;
      last_lat = run;
      last_data = data;
      last_err = error;
      last_tp = tp;
      last_wr = wrack;
    end
    if (cs_int != 4'b0 && !$isunknown(cs_int)) begin
      if (run == 0) first_rd = rdce_int;
      run++;
    end else begin
      run = 0;
    end
  end

  function automatic int decode(logic [11:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic cur_err;
  logic [31:0] cur_data;
  bit spur0 = 0;

  task automatic drive_slaves(int sel, bit rd, bit ack);
    rdack_s = 4'($urandom);
    wrack_s = 4'($urandom);
    error_s = 4'($urandom);
    data_s = {$urandom, $urandom, $urandom, $urandom};
    if (spur0) rdack_s[0] = 1'b1;
    if (sel >= 0) begin
      rdack_s[sel] = rd & ack;
      wrack_s[sel] = !rd & ack;
      if (ack) begin
        error_s[sel] = cur_err;
        data_s[sel*32 +: 32] = cur_data;
      end
    end
  endtask

  // delay: cycle (counted from first *_int cycle) of slave ack, 0 = never
  task automatic txn(logic [11:0] a, bit rd, bit wr, int delay, int hold,
                     int abort_at, int extra, logic e, logic [31:0] d);
    int idx;
    bit hitv, aborted, acked;
    logic [3:0] oh;
    idx = decode(a);
    hitv = (idx >= 0) && (rd != wr);
    aborted = 0;
    acked = 0;
    oh = '0;
    if (hitv) oh[idx] = 1'b1;
    cur_err = e;
    cur_data = d;
    addr = a; cs = 1; rdce = rd; wrce = wr;
    drive_slaves(-1, 0, 0);
    clr_exp();
    tick();
    if (!hitv) begin
      set_exp(4'b0, 4'b0, 4'b0, rd & !wr, wr, 1'b1, 32'b0, 1'b0);
    end else begin
      for (int c = 1; c <= T; c++) begin
        set_exp(oh, rd ? oh : 4'b0, wr ? oh : 4'b0, 0, 0, 0, 32'b0, 0);
        if (c == abort_at) begin
          cs = 0;
          drive_slaves(idx, rd, 0);
          tick();
          clr_exp();
          aborted = 1;
          break;
        end
        drive_slaves(idx, rd, c == delay);
        tick();
        if (c == delay) begin
          set_exp(4'b0, 4'b0, 4'b0, rd, wr, e, rd ? d : 32'b0, 1'b0);
          acked = 1;
          break;
        end
        if (c == T)
          set_exp(4'b0, 4'b0, 4'b0, rd, wr, 1'b1, 32'b0, 1'b1);
      end
    end
    if (!aborted)
      for (int j = 0; j < extra; j++) begin
        drive_slaves(hitv ? idx : -1, rd, acked && (j + 1 < hold));
        tick();
        clr_exp();
      end
    cs = 1'($urandom); rdce = 0; wrce = 0;
    drive_slaves(-1, 0, 0);
    tick();
    clr_exp();
  endtask

  int base_cnt;
  logic [11:0] ra;
  int k, dly, hld, abt;

  initial begin
    clr_exp();
    repeat (3) tick();
    chk("reset_state", {cs_int, rdce_int, wrce_int, rdack, wrack, error, tp, data}, 64'b0);
    chk("dec_404", 64'(decode(12'h404)), 64'(1));
    chk("dec_0f0", 64'(decode(12'h0F0)), 64'(-1));
    chk("dec_610", 64'(decode(12'h610)), 64'(2));
    chk("dec_7f0", 64'(decode(12'h7F0)), 64'(3));
    rst_n = 1;
    tick();

    // Overlapping-window instance: lowest index wins
    addr = 12'h680; cs = 1; rdce = 1;
    tick();
    set_exp(4'b0100, 4'b0100, 4'b0, 0, 0, 0, 32'b0, 0);
    chk("ovl_680", cs2, 6'b000100);
    cs = 0;
    tick();
    clr_exp();
    rdce = 0;
    tick();
    addr = 12'h780; cs = 1; rdce = 1;
    tick();
    set_exp(4'b1000, 4'b1000, 4'b0, 0, 0, 0, 32'b0, 0);
    chk("ovl_780", cs2, 6'b100000);
    cs = 0;
    tick();
    clr_exp();
    rdce = 0;

    // cs without strobe keeps the decoder idle
    cs = 1;
    repeat (3) tick();
    cs = 0;
    tick();

    base_cnt = ack_cnt;
    txn(12'h404, 1, 0, 3, 1, 0, 1, 1'b0, 32'hDEADBEEF);
    chk("t1_rdce_int", first_rd, 4'b0010);
    chk("t1_data", last_data, 32'hDEADBEEF);
    chk("t1_err", last_err, 1'b0);
    chk("t1_lat", last_lat, 3);
    chk("t1_acks", ack_cnt - base_cnt, 1);

    base_cnt = ack_cnt;
    txn(12'h0F0, 0, 1, 0, 1, 0, 1, 1'b0, 32'h0);
    chk("t2_err", last_err, 1'b1);
    chk("t2_lat", last_lat, 0);
    chk("t2_acks", ack_cnt - base_cnt, 1);

    base_cnt = ack_cnt;
    txn(12'h610, 1, 0, 0, 1, 0, 1, 1'b0, 32'h0);
    chk("t3_rdce_int", first_rd, 4'b0100);
    chk("t3_lat", last_lat, T);
    chk("t3_tp", last_tp, 1'b1);
    chk("t3_err", last_err, 1'b1);
    chk("t3_data", last_data, 32'h0);
    chk("t3_acks", ack_cnt - base_cnt, 1);

    base_cnt = ack_cnt;
    spur0 = 1;
    txn(12'h7F0, 0, 1, 2, 4, 0, 5, 1'b0, 32'h0);
    spur0 = 0;
    chk("t4_acks", ack_cnt - base_cnt, 1);
    chk("t4_wr", last_wr, 1'b1);

    // Reset in BUSY, then master abort
    base_cnt = ack_cnt;
    addr = 12'h404; cs = 1; rdce = 1; wrce = 0;
    drive_slaves(-1, 0, 0);
    tick();
    set_exp(4'b0010, 4'b0010, 4'b0, 0, 0, 0, 32'b0, 0);
    drive_slaves(1, 1, 0);
    tick();
    #2;
    rst_n = 0;
    clr_exp();
    #1;
    chk("t5_rst_async", {cs_int, rdce_int, wrce_int, rdack, wrack, error, tp, data}, 64'b0);
    cs = 0; rdce = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    txn(12'h404, 1, 0, 0, 1, 2, 1, 1'b0, 32'h0);
    chk("t5_no_ack", ack_cnt - base_cnt, 0);
    txn(12'h204, 1, 0, 1, 1, 0, 0, 1'b0, 32'h1234_5678);
    chk("t5_data", last_data, 32'h1234_5678);
    chk("t5_acks", ack_cnt - base_cnt, 1);

    txn(12'h404, 1, 1, 2, 1, 0, 1, 1'b0, 32'h0);
    chk("both_wr", last_wr, 1'b1);
    chk("both_err", last_err, 1'b1);

    for (int n = 0; n < 200; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                        : 12'($urandom_range(12'h200, 12'h7FF));
      k = $urandom_range(0, 9);
      dly = $urandom_range(0, 10);
      hld = $urandom_range(1, 4);
      abt = ($urandom_range(0, 9) == 0) ? $urandom_range(1, T) : 0;
      if (dly != 0 && dly <= abt) abt = 0;
      txn(ra, (k < 5) || (k == 9), k >= 5, dly, hld, abt,
          $urandom_range(0, 3), 1'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_ethernet_v3_01_a_ipic_decode_mux.md
Name: axi_ethernet_v3_01_a_ipic_decode_mux

Overview:
- Parametrised IPIC address decoder and response multiplexer between the IPIC slave front end and N internal register blocks (stats, MAC config, interrupt controller, address filter, and future additions).
- Decodes the address against per-slave base/mask pairs and drives registered one-hot chip-select and RdCE/WrCE lines.
- Accepts the ack only from the selected slave, so each transaction produces exactly one ack pulse.
- Generates an error response for unmapped addresses, illegal strobes and slave timeout.

Parameters:
- C_NUM_SLAVES, 4: number of downstream register blocks (1..16).
- C_ADDR_WIDTH, 12: width of bus2ip_addr.
- C_DATA_WIDTH, 32: read data width.
- C_BASE_ADDRS, 48'h700_600_400_200: packed bases; slave i occupies [i*C_ADDR_WIDTH +: C_ADDR_WIDTH].
- C_ADDR_MASKS, 48'h700_700_600_600: packed masks. Slave i hits when (addr & mask_i) == base_i.
- C_TIMEOUT, 64: cycles to wait for a slave ack. 0 disables the timeout.

Ports:
- bus2ip_clk  in  1  sole clock.
- bus2ip_resetn  in  1  reset, asynchronous assert, active-low.
- bus2ip_addr  in  C_ADDR_WIDTH  transaction address.
- bus2ip_cs  in  1  chip select from the IPIC front end.
- bus2ip_rdce  in  1  read strobe (level).
- bus2ip_wrce  in  1  write strobe (level).
- bus2ip_cs_int  out  C_NUM_SLAVES  one-hot per-slave chip select.
- bus2ip_rdce_int  out  C_NUM_SLAVES  one-hot per-slave read enable.
- bus2ip_wrce_int  out  C_NUM_SLAVES  one-hot per-slave write enable.
- ip2bus_rdack_s  in  C_NUM_SLAVES  per-slave read ack.
- ip2bus_wrack_s  in  C_NUM_SLAVES  per-slave write ack.
- ip2bus_error_s  in  C_NUM_SLAVES  per-slave error, qualified by that slave's ack.
- ip2bus_data_s  in  C_NUM_SLAVES*C_DATA_WIDTH  packed slave read data; slave i at [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- ip2bus_rdack  out  1  single-cycle read ack.
- ip2bus_wrack  out  1  single-cycle write ack.
- ip2bus_error  out  1  error, valid with the ack.
- ip2bus_data  out  C_DATA_WIDTH  read data, valid with rdack, 0 otherwise.
- timeout_pulse  out  1  one-cycle pulse on a slave timeout, for the interrupt controller.

Behaviour:

Reset:
- bus2ip_resetn low asynchronously clears all outputs to 0, clears the timeout counter and forces state IDLE.
- Reset asserted mid-transaction aborts it; no ack is issued.

All outputs are registered.

State IDLE:
- Entered on bus2ip_cs=1 with exactly one of rdce/wrce high.
- Hit selection: the lowest-index hitting slave wins.
- Hit, slave i: on the next edge bit i of cs_int and of rdce_int or wrce_int (matching the strobe) is set, the counter is loaded with C_TIMEOUT, go BUSY.
- No hit: on the next edge pulse rdack or wrack (matching the strobe) with error=1, data=0, go DONE.
- rdce and wrce both high with cs: treated as no hit, error response with wrack=1 and rdack=0, go DONE.
- cs=1 with no strobe: stay IDLE.

State BUSY:
- The *_int outputs hold their value.
- Only acks from the selected slave count. Acks from other slaves are ignored.
- Selected slave's rdack or wrack=1 at cycle k:
  - at k+1 ip2bus_rdack or ip2bus_wrack=1 for one cycle;
  - ip2bus_error = that slave's error sampled at k;
  - for a read, ip2bus_data = that slave's data sampled at k;
  - *_int are cleared at k+1; go DONE.
- Otherwise, when C_TIMEOUT>0, the counter decrements each cycle. When it is 1 with no ack, on the next edge:
  - matching ack=1, error=1, data=0, timeout_pulse=1;
  - *_int cleared; go DONE.
- The timeout ack therefore appears C_TIMEOUT cycles after *_int first assert.
- bus2ip_cs low while in BUSY (master abort): *_int cleared, no ack, go IDLE.
- An ack arriving in the same cycle the counter expires: the slave ack wins, error = slave error, no timeout_pulse.

State DONE:
- Ack, error and data return to 0 one cycle after the ack pulse.
- Stay in DONE while bus2ip_cs=1 and (rdce|wrce)=1. This blocks re-decode of the same request and ignores slave acks held for several cycles.
- Go IDLE when cs=0 or both strobes are 0.

Latency:
- Request to *_int: 1 cycle.
- Slave ack to ip2bus ack: 1 cycle.
- Unmapped request to error ack: 1 cycle.
- Back-to-back requests need at least one idle strobe cycle between them.

Test Plan:
- Read 0x404, slave 1 rdack after 3 cycles with data 0xDEADBEEF -> rdce_int=4'b0010 at cycle 1; ip2bus_rdack=1 for one cycle with data 0xDEADBEEF, error=0.
- Write 0x0F0 (unmapped) -> wrack=1, error=1 at cycle 1; cs_int stays 0.
- Read 0x610, C_TIMEOUT=8, no slave ack -> rdce_int=4'b0100; rdack=1, error=1, data=0, timeout_pulse=1 exactly 8 cycles after rdce_int asserts.
- Slave 3 holds wrack high for 4 cycles and slave 0 spuriously asserts rdack -> exactly one wrack pulse; slave 0 ack ignored.
- Reset low during BUSY, then cs dropped during BUSY in a second transaction -> all outputs 0 immediately on reset; no ack in either case; next read 0x204 completes normally.
- Parameter override: C_NUM_SLAVES=6, overlapping masks on slaves 2 and 5 -> address hitting both selects slave 2 only.
